coin_acceptor: RTL and testbench
================================

Name: coin_acceptor

Overview:
Front-end stage that sits directly upstream of the vending machine FSM and drives its 2-bit coin input. It synchronises and debounces two raw coin-sensor lines (5-unit and 10-unit), detects jammed sensors and queues validated coins in a small FIFO. Coins are presented downstream as single-cycle codes (01 = 5, 10 = 10), always separated by at least one idle (00) cycle. Rejected coins produce a reject pulse that drives the return-flap actuator.

Parameters:
DEBOUNCE, 4, consecutive synchronised-high cycles required to qualify a coin; also the consecutive low cycles required to release; minimum 2
JAM_CYCLES, 64, cycles a sensor may stay high in HELD before the channel is declared jammed
FIFO_DEPTH, 4, number of queued coin codes; power of two, minimum 2

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high; clears all state
sens_a  input  1  raw 5-unit sensor, asynchronous, may glitch
sens_b  input  1  raw 10-unit sensor, asynchronous, may glitch
coin_enable  input  1  1 = accept coins; 0 = every qualified coin is rejected
hold  input  1  downstream stall; while 1, no coin is popped or emitted
coin  output  2  coin code to the vending machine: 00 none, 01 = 5, 10 = 10; 11 is never driven
reject  output  1  one-cycle pulse per rejected coin
jam  output  1  registered OR of both channels' JAM state
fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Interface: one clock; reset is synchronous and active-high (clock port clk, reset port reset).
- Reset: coin=00, reject=0, jam=0, fifo_count=0. Synchroniser flops=0. Both channel FSMs go to IDLE and all counters clear. Reset mid-operation discards all queued coins.
- Synchroniser: 2-FF per sensor. The FSMs see only the second-stage value s.
- Per-channel FSM with states IDLE, QUAL, HELD, JAM and one counter cnt:
  - IDLE: s=1 -> QUAL, cnt=1.
  - QUAL: s=0 -> IDLE (glitch, no event). s=1 and cnt==DEBOUNCE-1 -> HELD, cnt=0, qualify event. Otherwise cnt++.
  - HELD: s=1 -> cnt++; when cnt reaches JAM_CYCLES-1 -> JAM, cnt=0. s=0 -> count consecutive lows; DEBOUNCE lows -> IDLE. Any high resets the low count.
  - JAM: leaves only after DEBOUNCE consecutive lows, then -> IDLE. No event is generated on exit.
- Event disposition on the edge the FSM enters HELD:
  - Both channels qualify on the same edge: both coins rejected. reject=1 for one cycle (a single pulse), nothing pushed.
  - coin_enable=0: reject.
  - FIFO full and no pop on this edge: reject.
  - Otherwise push the code. Push and pop on the same edge are legal, even when the FIFO is full.
- Emitter:
  - If coin!=00 this cycle, coin=00 next cycle (mandatory gap).
  - Else if hold=0 and the FIFO is not empty: pop, and coin=popped code for exactly one cycle.
  - Else coin=00.
  - hold is sampled every edge. hold rising while coin!=00 does not truncate the current one-cycle code.
- FIFO is strictly in-order. fifo_count updates on the same edge as the push/pop.
- Latency (empty FIFO, hold=0, coin_enable=0->1 settled): let edge 1 be the first edge that samples the sensor high. The push occurs at edge DEBOUNCE+2 and coin is valid after edge DEBOUNCE+3 (edge 7 at default).
- A sensor still high across reset deassertion re-qualifies from IDLE and produces a new event.
- The jam flag does not retract a coin already pushed on entry to HELD.

Test Plan:
1. sens_a high 12 cycles, coin_enable=1, hold=0 -> coin=01 for exactly one cycle after edge 7, no reject, coin returns to 00, no second event after release.
2. sens_b high 3 cycles then low (glitch < DEBOUNCE) -> coin stays 00, reject=0, fifo_count=0.
3. hold=1, five alternating sens_a/sens_b coins (each high 8, low 8) -> fifo_count reaches 4, fifth coin gives one reject pulse. Release hold -> codes 01,10,01,10 emitted on alternate cycles with 00 between, fifo_count steps down to 0.
4. sens_a and sens_b rise on the same edge, both held 10 cycles -> single reject pulse at edge 6, coin stays 00, fifo_count=0.
5. sens_b held 100 cycles -> coin=10 once. jam=1 from entry to JAM (about JAM_CYCLES after HELD entry). After DEBOUNCE low cycles jam=0, and no second coin is emitted.
6. hold=1 with 2 coins queued, assert reset for 1 cycle -> coin=00, fifo_count=0, jam=0. After hold=0, no stale coins are emitted. coin_enable=0 with a clean coin -> reject pulse, no coin.

Source files
------------

// File: rtl/coin_acceptor_if.sv
// Coin acceptor signal bundle: raw sensors and controls in,
// coin code, reject pulse, jam flag and FIFO occupancy out.
interface coin_acceptor_if #(
    parameter int FIFO_DEPTH = 4
);
    logic                        sens_a;
    logic                        sens_b;
    logic                        coin_enable;
    logic                        hold;
    logic [1:0]                  coin;
    logic                        reject;
    logic                        jam;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    modport master (
        output sens_a, sens_b, coin_enable, hold,
        input  coin, reject, jam, fifo_count
    );

    modport slave (
        input  sens_a, sens_b, coin_enable, hold,
        output coin, reject, jam, fifo_count
    );
endinterface

// File: rtl/coin_acceptor.sv
// Coin acceptor front end: sensor sync/debounce, jam detection,
// coin FIFO and gapped single-cycle coin emitter.
module coin_acceptor #(
    parameter int DEBOUNCE   = 4,
    parameter int JAM_CYCLES = 64,
    parameter int FIFO_DEPTH = 4
) (
    input logic             clk,
    input logic             reset,
    coin_acceptor_if.slave  bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(JAM_CYCLES + DEBOUNCE) + 1;
    localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE - 1);
    localparam logic [CW-1:0] JAM_LAST = CW'(JAM_CYCLES - 1);
    localparam logic [CW-1:0] ONE      = CW'(1);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, QUAL, HELD, JAM} ch_state_e;

    logic [1:0]    sync1_q, sync2_q;
    ch_state_e     st_q  [2];
    ch_state_e     st_d  [2];
    logic [CW-1:0] cnt_q [2];
    logic [CW-1:0] cnt_d [2];
    logic [CW-1:0] lo_q  [2];
    logic [CW-1:0] lo_d  [2];
    logic [1:0]    qual;

    logic [1:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   count_q, count_d;
    logic [1:0]    coin_q, coin_d;
    logic          reject_q, reject_d;
    logic          jam_q;
    logic          push, pop, full;
    logic [1:0]    push_code;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 2'b00;
            sync2_q <= 2'b00;
        end else begin
            sync1_q <= {bus.sens_b, bus.sens_a};
            sync2_q <= sync1_q;
        end
    end

    // Channel 0 is the 5-unit sensor, channel 1 the 10-unit sensor
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            st_d[i]  = st_q[i];
            cnt_d[i] = cnt_q[i];
            lo_d[i]  = lo_q[i];
            qual[i]  = 1'b0;
            case (st_q[i])
                IDLE: begin
                    if (sync2_q[i]) begin
                        st_d[i]  = QUAL;
                        cnt_d[i] = ONE;
                        lo_d[i]  = '0;
                    end
                end
                QUAL: begin
                    if (!sync2_q[i]) begin
                        st_d[i]  = IDLE;
                        cnt_d[i] = '0;
                    end else if (cnt_q[i] == DEB_LAST) begin
                        st_d[i]  = HELD;
                        cnt_d[i] = '0;
                        lo_d[i]  = '0;
                        qual[i]  = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + ONE;
                    end
                end
                HELD: begin
                    if (sync2_q[i]) begin
                        lo_d[i] = '0;
                        if (cnt_q[i] == JAM_LAST) begin
                            st_d[i]  = JAM;
                            cnt_d[i] = '0;
                        end else begin
                            cnt_d[i] = cnt_q[i] + ONE;
                        end
                    end else if (lo_q[i] == DEB_LAST) begin
                        st_d[i]  = IDLE;
                        cnt_d[i] = '0;
                        lo_d[i]  = '0;
                    end else begin
                        lo_d[i] = lo_q[i] + ONE;
                    end
                end
                JAM: begin
                    if (sync2_q[i]) begin
                        lo_d[i] = '0;
                    end else if (lo_q[i] == DEB_LAST) begin
                        st_d[i] = IDLE;
                        lo_d[i] = '0;
                    end else begin
                        lo_d[i] = lo_q[i] + ONE;
                    end
                end
                default: st_d[i] = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                st_q[i]  <= IDLE;
                cnt_q[i] <= '0;
                lo_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                st_q[i]  <= st_d[i];
                cnt_q[i] <= cnt_d[i];
                lo_q[i]  <= lo_d[i];
            end
        end
    end

    // Simultaneous qualification is ambiguous, so both coins go back
    always_comb begin
        full      = (count_q == FULL_CNT);
        pop       = (coin_q == 2'b00) && !bus.hold && (count_q != '0);
        push      = 1'b0;
        reject_d  = 1'b0;
        push_code = qual[0] ? 2'b01 : 2'b10;
        if (qual[0] && qual[1]) begin
            reject_d = 1'b1;
        end else if (qual != 2'b00) begin
            if (!bus.coin_enable || (full && !pop)) begin
                reject_d = 1'b1;
            end else begin
                push = 1'b1;
            end
        end
        count_d = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        coin_d  = 2'b00;
        if (coin_q == 2'b00 && pop) begin
            coin_d = mem_q[rd_q];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_q] <= push_code;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q     <= '0;
            rd_q     <= '0;
            count_q  <= '0;
            coin_q   <= 2'b00;
            reject_q <= 1'b0;
            jam_q    <= 1'b0;
        end else begin
            if (push) wr_q <= wr_q + AW'(1);
            if (pop)  rd_q <= rd_q + AW'(1);
            count_q  <= count_d;
            coin_q   <= coin_d;
            reject_q <= reject_d;
            jam_q    <= (st_q[0] == JAM) || (st_q[1] == JAM);
        end
    end

    assign bus.coin       = coin_q;
    assign bus.reject     = reject_q;
    assign bus.jam        = jam_q;
    assign bus.fifo_count = count_q;
endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor with a coin-code scoreboard
// and a negedge monitor for codes, gaps and reject pulses.
module tb_coin_acceptor;
    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   rej_cnt  = 0;
    int   coin_cnt = 0;
    logic [1:0] prev_coin = 2'b00;
    logic [1:0] exp_q[$];

    coin_acceptor_if #(.FIFO_DEPTH(4)) bus ();

    coin_acceptor #(
        .DEBOUNCE(4),
        .JAM_CYCLES(64),
        .FIFO_DEPTH(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (bus.reject === 1'b1) rej_cnt++;
        if (prev_coin !== 2'b00) chk("gap", int'(bus.coin), 0);
        if (bus.coin !== 2'b00) begin
            coin_cnt++;
            if (exp_q.size() == 0) chk("sb_extra", int'(bus.coin), 0);
            else chk("sb_code", int'(bus.coin), int'(exp_q.pop_front()));
        end
        prev_coin = bus.coin;
    end

    task automatic coin_pulse(input bit chan_b, input int hi, input int lo);
        if (chan_b) bus.sens_b = 1'b1;
        else        bus.sens_a = 1'b1;
        tick(hi);
        bus.sens_a = 1'b0;
        bus.sens_b = 1'b0;
        tick(lo);
    endtask

    initial begin
        int rb, cb, first;
        reset           = 1'b1;
        bus.sens_a      = 1'b0;
        bus.sens_b      = 1'b0;
        bus.coin_enable = 1'b1;
        bus.hold        = 1'b0;
        tick(3);
        chk("rst_coin", int'(bus.coin), 0);
        chk("rst_reject", int'(bus.reject), 0);
        chk("rst_jam", int'(bus.jam), 0);
        chk("rst_count", int'(bus.fifo_count), 0);
        reset = 1'b0;
        tick(2);

        // single 5-unit coin, latency to emission
        exp_q.push_back(2'b01);
        bus.sens_a = 1'b1;
        tick(6);
        chk("t1_push", int'(bus.fifo_count), 1);
        chk("t1_early", int'(bus.coin), 0);
        tick(1);
        chk("t1_coin", int'(bus.coin), 1);
        chk("t1_pop", int'(bus.fifo_count), 0);
        tick(5);
        bus.sens_a = 1'b0;
        tick(20);
        chk("t1_rej", rej_cnt, 0);
        chk("t1_ncoin", coin_cnt, 1);
        chk("t1_sb", exp_q.size(), 0);

        // short glitch on the 10-unit sensor
        coin_pulse(1'b1, 3, 15);
        chk("t2_count", int'(bus.fifo_count), 0);
        chk("t2_rej", rej_cnt, 0);
        chk("t2_ncoin", coin_cnt, 1);

        // fill FIFO under hold, fifth coin rejected, then drain
        bus.hold = 1'b1;
        rb = rej_cnt;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) exp_q.push_back((i % 2 == 0) ? 2'b01 : 2'b10);
            coin_pulse(i % 2 == 1, 8, 8);
        end
        chk("t3_full", int'(bus.fifo_count), 4);
        chk("t3_rej", rej_cnt - rb, 1);
        chk("t3_held", coin_cnt, 1);
        bus.hold = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick(1);
            chk("t3_drain", int'(bus.fifo_count), 3 - k / 2);
        end
        tick(2);
        chk("t3_sb", exp_q.size(), 0);
        chk("t3_ncoin", coin_cnt, 5);

        // simultaneous coins: one reject pulse at edge 6
        rb = rej_cnt;
        cb = coin_cnt;
        bus.sens_a = 1'b1;
        bus.sens_b = 1'b1;
        tick(5);
        chk("t4_pre", int'(bus.reject), 0);
        tick(1);
        chk("t4_pulse", int'(bus.reject), 1);
        tick(1);
        chk("t4_post", int'(bus.reject), 0);
        tick(3);
        bus.sens_a = 1'b0;
        bus.sens_b = 1'b0;
        tick(15);
        chk("t4_rej", rej_cnt - rb, 1);
        chk("t4_ncoin", coin_cnt - cb, 0);
        chk("t4_count", int'(bus.fifo_count), 0);

        // stuck 10-unit sensor: one coin then jam
        cb = coin_cnt;
        first = 0;
        exp_q.push_back(2'b10);
        bus.sens_b = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            tick(1);
            if (first == 0 && bus.jam === 1'b1) first = k;
        end
        chk("t5_jam_rise", int'(first >= 60 && first <= 80), 1);
        chk("t5_jam_hi", int'(bus.jam), 1);
        bus.sens_b = 1'b0;
        tick(3);
        chk("t5_jam_hold", int'(bus.jam), 1);
        tick(10);
        chk("t5_jam_clr", int'(bus.jam), 0);
        tick(20);
        chk("t5_ncoin", coin_cnt - cb, 1);
        chk("t5_sb", exp_q.size(), 0);

        // reset discards queued coins; disabled acceptor rejects
        bus.hold = 1'b1;
        cb = coin_cnt;
        coin_pulse(1'b0, 8, 8);
        coin_pulse(1'b1, 8, 8);
        chk("t6_queued", int'(bus.fifo_count), 2);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chk("t6_coin", int'(bus.coin), 0);
        chk("t6_count", int'(bus.fifo_count), 0);
        chk("t6_jam", int'(bus.jam), 0);
        bus.hold = 1'b0;
        tick(10);
        chk("t6_stale", coin_cnt - cb, 0);
        rb = rej_cnt;
        bus.coin_enable = 1'b0;
        coin_pulse(1'b0, 8, 10);
        chk("t6_rej", rej_cnt - rb, 1);
        chk("t6_ncoin", coin_cnt - cb, 0);
        chk("t6_count2", int'(bus.fifo_count), 0);
        chk("end_sb", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
